// File: rtl/issue_div_fifo_pkg.sv
// issue_div_fifo_pkg
//   Shared issue->execute types and the default queue depth.
//   issue_execute_pack_t : divide micro-op handed from issue to execute_div
//   ISSUE_DIV_FIFO_DEPTH : default DEPTH for issue_div_fifo
//   is_pow2()            : elaboration-time depth sanity check
package issue_div_fifo_pkg;

  localparam int ISSUE_DIV_FIFO_DEPTH = 4;

  typedef struct packed {
    logic        enable;
    logic [5:0]  rob_id;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
  } issue_execute_pack_t;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/issue_div_fifo_if.sv
// issue_div_fifo_if
//   Bundle between issue/commit/execute_div and issue_div_fifo.
//   master : driven by the pipeline (data_in, push, pop, flush),
//            observes full, data_out, data_out_valid, count
//   slave  : the FIFO side of the same signals
import issue_div_fifo_pkg::*;

interface issue_div_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  issue_execute_pack_t issue_div_fifo_data_in;
  logic                issue_div_fifo_push;
  logic                issue_div_fifo_full;
  issue_execute_pack_t issue_div_fifo_data_out;
  logic                issue_div_fifo_data_out_valid;
  logic                issue_div_fifo_pop;
  logic                issue_div_fifo_flush;
  logic [CNT_W-1:0]    issue_div_fifo_count;

  modport master (
    output issue_div_fifo_data_in, issue_div_fifo_push,
           issue_div_fifo_pop, issue_div_fifo_flush,
    input  issue_div_fifo_full, issue_div_fifo_data_out,
           issue_div_fifo_data_out_valid, issue_div_fifo_count
  );

  modport slave (
    input  issue_div_fifo_data_in, issue_div_fifo_push,
           issue_div_fifo_pop, issue_div_fifo_flush,
    output issue_div_fifo_full, issue_div_fifo_data_out,
           issue_div_fifo_data_out_valid, issue_div_fifo_count
  );
endinterface

// File: rtl/issue_div_fifo_ptr_ctrl.sv
// fifo_ptr_ctrl
//   Read/write pointer bookkeeping for a power-of-two FIFO. Pointers carry
//   one extra MSB so full and empty are distinguishable; all arithmetic is
//   modulo 2*DEPTH. Reusable by any issue->execute queue.
//   clk, rst        : clock, async active-low reset
//   push, pop       : raw requests; flush clears both pointers (highest priority)
//   widx, ridx      : storage indices for write and head
//   full, empty     : occupancy flags from registered pointers
//   count           : wptr - rptr
//   push_acc        : a write must happen at widx this edge
module fifo_ptr_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  output logic [$clog2(DEPTH)-1:0]  widx,
  output logic [$clog2(DEPTH)-1:0]  ridx,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      push_acc
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             pop_acc;

  assign full  = (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]) && (wptr[IDX_W] != rptr[IDX_W]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign widx  = wptr[IDX_W-1:0];
  assign ridx  = rptr[IDX_W-1:0];

  // full/empty come from the pre-edge pointers, so a pop never frees a
  // slot for a push in the same cycle
  assign push_acc = push && !full && !flush;
  assign pop_acc  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_acc) wptr <= wptr + PTR_W'(1);
      if (pop_acc)  rptr <= rptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/issue_div_fifo.sv
// issue_div_fifo
//   First-word-fall-through queue of divide micro-ops between issue and
//   execute_div. Commit flush empties it so no wrong-path op reaches the divider.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : issue_div_fifo_if.slave (data_in/push, data_out/valid/pop,
//          flush, full, count)
//   Optional: ISSUE_DIV_FIFO_BYPASS_EN forwards data_in straight to data_out
//   while the queue is empty; a same-cycle pop consumes it without a write.
import issue_div_fifo_pkg::*;

module issue_div_fifo #(
  parameter int DEPTH = ISSUE_DIV_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  issue_div_fifo_if.slave   bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $error("issue_div_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [IDX_W-1:0]    widx;
  logic [IDX_W-1:0]    ridx;
  logic                full;
  logic                empty;
  logic [IDX_W:0]      count;
  logic                push_acc;
  logic                push_q;
  logic                bypass;
  issue_execute_pack_t mem [DEPTH];

`ifdef ISSUE_DIV_FIFO_BYPASS_EN
  assign bypass = empty && bus.issue_div_fifo_push && !bus.issue_div_fifo_flush;
  // a bypassed entry popped in the same cycle is never stored
  assign push_q = bus.issue_div_fifo_push && !(bypass && bus.issue_div_fifo_pop);
`else
  assign bypass = 1'b0;
  assign push_q = bus.issue_div_fifo_push;
`endif

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .push     (push_q),
    .pop      (bus.issue_div_fifo_pop),
    .flush    (bus.issue_div_fifo_flush),
    .widx     (widx),
    .ridx     (ridx),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .push_acc (push_acc)
  );

  always_ff @(posedge clk) begin
    if (push_acc) mem[widx] <= bus.issue_div_fifo_data_in;
  end

  always_comb begin
    bus.issue_div_fifo_data_out       = '0;
    bus.issue_div_fifo_data_out_valid = !empty;
    if (bypass) begin
      bus.issue_div_fifo_data_out       = bus.issue_div_fifo_data_in;
      bus.issue_div_fifo_data_out_valid = 1'b1;
    end else if (!empty) begin
      bus.issue_div_fifo_data_out = mem[ridx];
    end
  end

  assign bus.issue_div_fifo_full  = full;
  assign bus.issue_div_fifo_count = CNT_W'(count);

endmodule

// File: tb/tb_issue_div_fifo.sv
// tb_issue_div_fifo
//   Directed stimulus against a queue-based reference of issue_div_fifo.
//   Build with ISSUE_DIV_FIFO_BYPASS_EN to exercise the bypass path.
import issue_div_fifo_pkg::*;

module tb_issue_div_fifo;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  issue_div_fifo_if #(.DEPTH(DEPTH)) bus();

  issue_div_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  issue_execute_pack_t q[$];

  function automatic issue_execute_pack_t mk(input int rob);
    issue_execute_pack_t p;
    p        = '0;
    p.enable = 1'b1;
    p.rob_id = 6'(rob);
    p.op     = 3'(rob % 5);
    p.src_a  = 32'(rob) * 32'h0101_0101;
    p.src_b  = ~p.src_a;
    return p;
  endfunction

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_p(input string name, input issue_execute_pack_t act,
                       input issue_execute_pack_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expected outputs from the queue contents (and current inputs
  // when the bypass path is built in).
  always @(negedge clk) begin
    issue_execute_pack_t ed;
    bit ev;
    if (cmp_en) begin
      ev = (q.size() != 0);
      ed = ev ? q[0] : '0;
`ifdef ISSUE_DIV_FIFO_BYPASS_EN
      if (q.size() == 0 && bus.issue_div_fifo_push && !bus.issue_div_fifo_flush) begin
        ed = bus.issue_div_fifo_data_in;
        ev = 1'b1;
      end
`endif
      chk_i("m_count", int'(bus.issue_div_fifo_count), q.size());
      chk_i("m_full",  int'(bus.issue_div_fifo_full), int'(q.size() == DEPTH));
      chk_i("m_valid", int'(bus.issue_div_fifo_data_out_valid), int'(ev));
      chk_p("m_data",  bus.issue_div_fifo_data_out, ed);
    end
  end

  task automatic drive(input bit pu, input bit po, input bit fl, input issue_execute_pack_t d);
    bus.issue_div_fifo_push    = pu;
    bus.issue_div_fifo_pop     = po;
    bus.issue_div_fifo_flush   = fl;
    bus.issue_div_fifo_data_in = d;
  endtask

  // One clock edge; the reference queue follows the same inputs the DUT saw.
  task automatic step();
    int n;
    bit byp;
    @(posedge clk);
    n   = q.size();
    byp = 1'b0;
`ifdef ISSUE_DIV_FIFO_BYPASS_EN
    byp = (n == 0) && bus.issue_div_fifo_push && bus.issue_div_fifo_pop;
`endif
    if (!rst || bus.issue_div_fifo_flush) begin
      q.delete();
    end else if (!byp) begin
      if (bus.issue_div_fifo_pop && n > 0) void'(q.pop_front());
      if (bus.issue_div_fifo_push && n < DEPTH) q.push_back(bus.issue_div_fifo_data_in);
    end
    #1;
  endtask

  task automatic cyc(input bit pu, input bit po, input bit fl, input issue_execute_pack_t d);
    drive(pu, po, fl, d);
    step();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0);

    // reset held with clock running
    repeat (2) @(posedge clk);
    #1;
    chk_i("rst_full",   int'(bus.issue_div_fifo_full), 0);
    chk_i("rst_valid",  int'(bus.issue_div_fifo_data_out_valid), 0);
    chk_i("rst_count",  int'(bus.issue_div_fifo_count), 0);
    chk_i("rst_enable", int'(bus.issue_div_fifo_data_out.enable), 0);
    rst    = 1'b1;
    cmp_en = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, '0);
    chk_i("idle_valid", int'(bus.issue_div_fifo_data_out_valid), 0);
    chk_i("idle_count", int'(bus.issue_div_fifo_count), 0);

    // fill, overflow drop, drain in order
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, mk(i));
      chk_i("fill_count", int'(bus.issue_div_fifo_count), i);
    end
    chk_i("fill_full", int'(bus.issue_div_fifo_full), 1);
    chk_i("fill_head", int'(bus.issue_div_fifo_data_out.rob_id), 1);
    cyc(1'b1, 1'b0, 1'b0, mk(5));
    chk_i("drop_count", int'(bus.issue_div_fifo_count), 4);
    for (int i = 1; i <= 4; i++) begin
      chk_i("pop_order", int'(bus.issue_div_fifo_data_out.rob_id), i);
      cyc(1'b0, 1'b1, 1'b0, '0);
    end
    chk_i("drain_valid", int'(bus.issue_div_fifo_data_out_valid), 0);

    // wrap-around
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, mk(20 + i));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    for (int i = 10; i <= 13; i++) cyc(1'b1, 1'b0, 1'b0, mk(i));
    chk_i("wrap_count", int'(bus.issue_div_fifo_count), 4);
    chk_i("wrap_full",  int'(bus.issue_div_fifo_full), 1);
    for (int i = 10; i <= 13; i++) begin
      chk_i("wrap_order", int'(bus.issue_div_fifo_data_out.rob_id), i);
      cyc(1'b0, 1'b1, 1'b0, '0);
    end

    // simultaneous push and pop at count 2
    cyc(1'b1, 1'b0, 1'b0, mk(5));
    cyc(1'b1, 1'b0, 1'b0, mk(6));
    cyc(1'b1, 1'b1, 1'b0, mk(7));
    chk_i("pp_count", int'(bus.issue_div_fifo_count), 2);
    chk_i("pp_head",  int'(bus.issue_div_fifo_data_out.rob_id), 6);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk_i("pp_last",  int'(bus.issue_div_fifo_data_out.rob_id), 7);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk_i("pp_empty", int'(bus.issue_div_fifo_data_out_valid), 0);

    // full with push and pop: push rejected, pop accepted
    for (int i = 40; i <= 43; i++) cyc(1'b1, 1'b0, 1'b0, mk(i));
    cyc(1'b1, 1'b1, 1'b0, mk(44));
    chk_i("fullpp_count", int'(bus.issue_div_fifo_count), 3);
    chk_i("fullpp_head",  int'(bus.issue_div_fifo_data_out.rob_id), 41);
    for (int i = 41; i <= 43; i++) begin
      chk_i("fullpp_order", int'(bus.issue_div_fifo_data_out.rob_id), i);
      cyc(1'b0, 1'b1, 1'b0, '0);
    end

    // flush beats push and pop
    for (int i = 30; i <= 32; i++) cyc(1'b1, 1'b0, 1'b0, mk(i));
    cyc(1'b1, 1'b1, 1'b1, mk(33));
    chk_i("flush_count", int'(bus.issue_div_fifo_count), 0);
    chk_i("flush_valid", int'(bus.issue_div_fifo_data_out_valid), 0);
    chk_p("flush_data",  bus.issue_div_fifo_data_out, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk_i("flush_stay", int'(bus.issue_div_fifo_data_out_valid), 0);

    // pop while empty is ignored
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk_i("epop_count", int'(bus.issue_div_fifo_count), 0);
    cyc(1'b1, 1'b0, 1'b0, mk(50));
    chk_i("epop_head", int'(bus.issue_div_fifo_data_out.rob_id), 50);
    cyc(1'b0, 1'b1, 1'b0, '0);

    // asynchronous reset mid-operation
    cyc(1'b1, 1'b0, 1'b0, mk(60));
    cyc(1'b1, 1'b0, 1'b0, mk(61));
    drive(1'b0, 1'b0, 1'b0, '0);
    #2 rst = 1'b0;
    q.delete();
    #1;
    chk_i("arst_count", int'(bus.issue_div_fifo_count), 0);
    chk_i("arst_valid", int'(bus.issue_div_fifo_data_out_valid), 0);
    chk_i("arst_full",  int'(bus.issue_div_fifo_full), 0);
    chk_p("arst_data",  bus.issue_div_fifo_data_out, '0);
    step();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk_i("arst_after", int'(bus.issue_div_fifo_count), 0);

`ifdef ISSUE_DIV_FIFO_BYPASS_EN
    drive(1'b1, 1'b1, 1'b0, mk(9));
    #1;
    chk_i("byp_valid", int'(bus.issue_div_fifo_data_out_valid), 1);
    chk_i("byp_rob",   int'(bus.issue_div_fifo_data_out.rob_id), 9);
    step();
    chk_i("byp_count", int'(bus.issue_div_fifo_count), 0);
    chk_i("byp_after", int'(bus.issue_div_fifo_data_out_valid), 0);
    drive(1'b1, 1'b0, 1'b0, mk(8));
    #1;
    chk_i("bypw_rob", int'(bus.issue_div_fifo_data_out.rob_id), 8);
    step();
    chk_i("bypw_count", int'(bus.issue_div_fifo_count), 1);
    chk_i("bypw_head",  int'(bus.issue_div_fifo_data_out.rob_id), 8);
    cyc(1'b0, 1'b1, 1'b0, '0);
`else
    drive(1'b1, 1'b1, 1'b0, mk(9));
    #1;
    chk_i("nobyp_valid", int'(bus.issue_div_fifo_data_out_valid), 0);
    step();
    chk_i("nobyp_count", int'(bus.issue_div_fifo_count), 1);
    chk_i("nobyp_head",  int'(bus.issue_div_fifo_data_out.rob_id), 9);
    cyc(1'b0, 1'b1, 1'b0, '0);
`endif

    repeat (2) cyc(1'b0, 1'b0, 1'b0, '0);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
